// File: rtl/cargador_memoria_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cargador_memoria_pkg                                                     |
// | Shared sizes and FSM state type for the stream/memory loader.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package cargador_memoria_pkg;

  localparam int c_DATA_W = 14;
  localparam int c_ADDR_W = 5;
  localparam int c_DEPTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cargador_memoria_contador_dir.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | contador_dir                                                             |
// | Address pointer (wrapping) and remaining-word counter for the loader.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module contador_dir #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  output logic [ADDR_W-1:0] o_ptr,
  output logic [ADDR_W:0]   o_rem
);

  localparam logic [ADDR_W:0]   c_DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] c_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   c_REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_rem;

  // Pointer wraps naturally at the top of the address space.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_rem <= '0;
    end else if (i_load) begin
      r_ptr <= i_base;
      r_rem <= (i_len > c_DEPTH) ? c_DEPTH : i_len;
    end else if (i_step) begin
      r_ptr <= r_ptr + c_PTR_ONE;
      r_rem <= r_rem - c_REM_ONE;
    end
  end

  assign o_ptr = r_ptr;
  assign o_rem = r_rem;

endmodule
`default_nettype wire

// File: rtl/cargador_memoria.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cargador_memoria                                                         |
// | Streams words into (load) or out of (dump) a memory block.               |
// | Optional running checksum output: CARGADOR_MEMORIA_CHECKSUM_EN.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cargador_memoria
  import cargador_memoria_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int ADDR_W = c_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef CARGADOR_MEMORIA_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] c_REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next;
  logic              w_start_acc;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W:0]   w_rem;

  assign w_start_acc = (r_state == ST_IDLE) && start;

  contador_dir #(
    .ADDR_W (ADDR_W)
  ) u_contador_dir (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_start_acc),
    .i_step (w_xfer),
    .i_base (base),
    .i_len  (len),
    .o_ptr  (w_ptr),
    .o_rem  (w_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Handshakes are masked during reset so an aborted load never writes.
  always_comb begin
    w_next    = r_state;
    w_xfer    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (r_state != ST_IDLE);
    done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) w_next = ST_DONE;
          else           w_next = mode ? ST_DUMP : ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = !rst;
        mem_addr = w_ptr;
        w_xfer   = in_valid && !rst;
        if (w_xfer) begin
          mem_en    = 1'b1;
          mem_wdata = in_data;
        end
      end
      ST_DUMP: begin
        out_valid = !rst;
        mem_addr  = w_ptr;
        out_data  = mem_rdata;
        w_xfer    = out_ready && !rst;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_xfer && (w_rem == c_REM_ONE)) w_next = ST_DONE;
  end

`ifdef CARGADOR_MEMORIA_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;
  logic [DATA_W-1:0] w_word;

  assign w_word = (r_state == ST_DUMP) ? mem_rdata : in_data;

  always_ff @(posedge clk) begin
    if (rst)              r_checksum <= '0;
    else if (w_start_acc) r_checksum <= '0;
    else if (w_xfer)      r_checksum <= r_checksum + w_word;
  end

  assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cargador_memoria.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cargador_memoria                                                      |
// | Directed self-checking bench for cargador_memoria with a memory model.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cargador_memoria;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [4:0]  base = '0;
  logic [5:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] out_data;
  logic        mem_en;
  logic [4:0]  mem_addr;
  logic [13:0] mem_wdata;
  logic [13:0] mem_rdata;
  logic        busy;
  logic        done;
`ifdef CARGADOR_MEMORIA_CHECKSUM_EN
  logic [13:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  logic [13:0] mem [32];
  logic [13:0] words_a [4];
  logic [13:0] words_b [4];

  cargador_memoria dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .base      (base),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
`ifdef CARGADOR_MEMORIA_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic m, input logic [4:0] b, input logic [5:0] l);
    start = 1'b1;
    mode  = m;
    base  = b;
    len   = l;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int n;
    logic seen_done;

    for (int i = 0; i < 32; i++) mem[i] = '0;
    words_a[0] = 14'h0011; words_a[1] = 14'h0022;
    words_a[2] = 14'h0033; words_a[3] = 14'h0044;
    words_b[0] = 14'h0100; words_b[1] = 14'h0101;
    words_b[2] = 14'h0102; words_b[3] = 14'h0103;

    // Reset state
    cyc(); cyc();
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_out_data", out_data, 0);
`ifdef CARGADOR_MEMORIA_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif

    // Reset wins over a simultaneous start
    start = 1'b1; mode = 1'b0; base = 5'd3; len = 6'd4;
    cyc();
    start = 1'b0;
    #2;
    check("rst_over_start_busy", busy, 0);
    rst = 1'b0;
    cyc();

    // Load base=3 len=4, continuous valid
    go(1'b0, 5'd3, 6'd4);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = words_a[i];
      #2;
      check("loadA_mem_en", mem_en, 1);
      check("loadA_in_ready", in_ready, 1);
      check("loadA_addr", mem_addr, 3 + i);
      check("loadA_wdata", mem_wdata, words_a[i]);
      check("loadA_done_low", done, 0);
      cyc();
    end
    in_valid = 1'b0;
    #2;
    check("loadA_done", done, 1);
    check("loadA_busy_done", busy, 1);
    check("loadA_no_mem_en", mem_en, 0);
    check("loadA_in_ready_done", in_ready, 0);
`ifdef CARGADOR_MEMORIA_CHECKSUM_EN
    check("loadA_checksum", checksum, 14'h00AA);
`endif
    cyc();
    #2;
    check("loadA_idle_done", done, 0);
    check("loadA_idle_busy", busy, 0);
    for (int i = 0; i < 4; i++) check("loadA_mem", mem[3 + i], words_a[i]);

    // Load base=30 len=4 wraps 30,31,0,1
    go(1'b0, 5'd30, 6'd4);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = words_b[i];
      #2;
      check("loadB_mem_en", mem_en, 1);
      check("loadB_addr", mem_addr, (30 + i) % 32);
      cyc();
    end
    in_valid = 1'b0;
    #2;
    check("loadB_done", done, 1);
    cyc();
    check("loadB_mem30", mem[30], 14'h0100);
    check("loadB_mem1", mem[1], 14'h0103);

    // Dump base=3 len=4, out_ready 1,0,1,0,...
    go(1'b1, 5'd3, 6'd4);
    for (int k = 0; k < 7; k++) begin
      out_ready = (k % 2 == 0);
      #2;
      check("dump_out_valid", out_valid, 1);
      check("dump_out_data", out_data, words_a[(k + 1) / 2]);
      check("dump_addr", mem_addr, 3 + (k + 1) / 2);
      check("dump_no_mem_en", mem_en, 0);
      check("dump_in_ready", in_ready, 0);
      cyc();
    end
    out_ready = 1'b0;
    #2;
    check("dump_done", done, 1);
    check("dump_out_valid_done", out_valid, 0);
    check("dump_out_data_done", out_data, 0);
`ifdef CARGADOR_MEMORIA_CHECKSUM_EN
    check("dump_checksum", checksum, 14'h00AA);
`endif
    cyc();

    // len=0 goes straight to DONE
    in_valid = 1'b1;
    in_data  = 14'h1234;
    go(1'b0, 5'd7, 6'd0);
    #2;
    check("len0_busy", busy, 1);
    check("len0_done", done, 1);
    check("len0_mem_en", mem_en, 0);
    check("len0_in_ready", in_ready, 0);
    cyc();
    #2;
    check("len0_idle_busy", busy, 0);
    check("len0_idle_done", done, 0);
    check("len0_idle_mem_en", mem_en, 0);
    in_valid = 1'b0;

    // len=40 clamps to 32; a start pulse mid-operation is ignored
    go(1'b0, 5'd0, 6'd40);
    n = 0;
    seen_done = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !seen_done; c++) begin
      in_data = 14'h0200 + 14'(c);
      start   = (c >= 5 && c < 10);
      mode    = 1'b1;
      #2;
      if (done) seen_done = 1'b1;
      else if (mem_en) n++;
      cyc();
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("len40_count", n, 32);
    check("len40_done_seen", seen_done, 1);
    #2;
    check("len40_idle", busy, 0);
    check("len40_mem31", mem[31], 14'h021F);

    // Reset after 2 of 4 load words
    go(1'b0, 5'd10, 6'd4);
    in_valid = 1'b1;
    in_data = 14'h0055; cyc();
    in_data = 14'h0066; cyc();
    rst = 1'b1;
    in_data = 14'h0077;
    #2;
    check("abort_rst_cycle_mem_en", mem_en, 0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      check("abort_busy", busy, 0);
      check("abort_mem_en", mem_en, 0);
      check("abort_done", done, 0);
      cyc();
    end
    in_valid = 1'b0;
    check("abort_mem10", mem[10], 14'h0055);
    check("abort_mem11", mem[11], 14'h0066);
    check("abort_mem12", mem[12], 14'h020C);

    // Fresh dump after abort
    go(1'b1, 5'd10, 6'd2);
    out_ready = 1'b1;
    #2;
    check("fresh_d0", out_data, 14'h0055);
    cyc();
    #2;
    check("fresh_d1", out_data, 14'h0066);
    cyc();
    #2;
    check("fresh_done", done, 1);
    out_ready = 1'b0;
    cyc();

    // Checksum wraps modulo 2**14
    go(1'b0, 5'd20, 6'd2);
    in_valid = 1'b1;
    in_data = 14'h3FFF; cyc();
    in_data = 14'h0002; cyc();
    in_valid = 1'b0;
    #2;
    check("wrap_done", done, 1);
`ifdef CARGADOR_MEMORIA_CHECKSUM_EN
    check("wrap_checksum", checksum, 14'h0001);
`endif
    cyc();
    check("wrap_mem21", mem[21], 14'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
